// File: rtl/serial_signed_divider.sv
// Signed multi-cycle divider: radix-2 restoring on magnitudes, one quotient bit per cycle,
// with a saturated narrow quotient, a full-width remainder and a divide-by-zero flag.
module serial_signed_divider #(
  parameter int unsigned WIDTH    = 28,
  parameter int unsigned OUT_SIZE = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [WIDTH-1:0]    dividend_in,
  input  logic [WIDTH-1:0]    divisor_in,
  input  logic                data_valid_in,
  output logic [OUT_SIZE-1:0] quotient_out,
  output logic [WIDTH-1:0]    remainder_out,
  output logic                data_valid_out,
  output logic                error_out,
  output logic                overflow_out,
  output logic                busy_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]    QMagNeg = WIDTH'(1) << (OUT_SIZE - 1);
  localparam logic [WIDTH-1:0]    QMagPos = QMagNeg - WIDTH'(1);
  localparam logic [OUT_SIZE-1:0] QOutMax = {1'b0, {(OUT_SIZE - 1){1'b1}}};
  localparam logic [OUT_SIZE-1:0] QOutMin = {1'b1, {(OUT_SIZE - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StDivide, StDone} state_e;

  state_e r_state, w_state_next;

  logic                r_dvd_neg;
  logic                r_dvs_neg;
  logic                r_div_zero;
  logic [WIDTH-1:0]    r_dividend;
  logic [WIDTH:0]      r_dvs_mag;
  logic [WIDTH-1:0]    r_quo;
  logic [WIDTH-1:0]    r_rem;
  logic [CntW-1:0]     r_cnt;

  logic [OUT_SIZE-1:0] r_quotient;
  logic [WIDTH-1:0]    r_remainder;
  logic                r_valid;
  logic                r_error;
  logic                r_overflow;

  logic [WIDTH-1:0]    w_dvd_mag;
  logic [WIDTH:0]      w_dvs_ext;
  logic [WIDTH:0]      w_dvs_mag;
  logic                w_div_zero;
  logic [WIDTH:0]      w_shift;
  logic [WIDTH:0]      w_sub;
  logic                w_fits;
  logic                w_last;
  logic                w_q_neg;
  logic                w_q_ovf;
  logic [OUT_SIZE-1:0] w_q_val;
  logic [WIDTH-1:0]    w_rem_val;

  // The W-bit unsigned view of |-2^(W-1)| is exact; the divisor is kept at W+1 bits.
  assign w_dvd_mag  = dividend_in[WIDTH-1] ? (~dividend_in + WIDTH'(1)) : dividend_in;
  assign w_dvs_ext  = {divisor_in[WIDTH-1], divisor_in};
  assign w_dvs_mag  = divisor_in[WIDTH-1] ? (~w_dvs_ext + (WIDTH + 1)'(1)) : w_dvs_ext;
  assign w_div_zero = (divisor_in == '0);

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_fits  = (w_shift >= r_dvs_mag);
  assign w_sub   = w_shift - r_dvs_mag;
  assign w_last  = (r_cnt == CntW'(WIDTH - 1));
  assign w_q_neg = r_dvd_neg ^ r_dvs_neg;

  always_comb begin
    w_q_ovf = 1'b0;
    w_q_val = r_quo[OUT_SIZE-1:0];
    if (w_q_neg) begin
      if (r_quo > QMagNeg) begin
        w_q_ovf = 1'b1;
        w_q_val = QOutMin;
      end else begin
        w_q_val = ~r_quo[OUT_SIZE-1:0] + OUT_SIZE'(1);
      end
    end else if (r_quo > QMagPos) begin
      w_q_ovf = 1'b1;
      w_q_val = QOutMax;
    end
  end

  assign w_rem_val = r_dvd_neg ? (~r_rem + WIDTH'(1)) : r_rem;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (data_valid_in) w_state_next = w_div_zero ? StDone : StDivide;
      StDivide: if (w_last) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_dvd_neg   <= 1'b0;
      r_dvs_neg   <= 1'b0;
      r_div_zero  <= 1'b0;
      r_dividend  <= '0;
      r_dvs_mag   <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (data_valid_in) begin
            r_dvd_neg  <= dividend_in[WIDTH-1];
            r_dvs_neg  <= divisor_in[WIDTH-1];
            r_div_zero <= w_div_zero;
            r_dividend <= dividend_in;
            r_dvs_mag  <= w_dvs_mag;
            r_quo      <= w_dvd_mag;
            r_rem      <= '0;
            r_cnt      <= '0;
          end
        end
        StDivide: begin
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          r_rem <= WIDTH'(w_fits ? w_sub : w_shift);
          r_cnt <= r_cnt + CntW'(1);
        end
        StDone: begin
          r_valid <= 1'b1;
          if (r_div_zero) begin
            r_quotient  <= '0;
            r_remainder <= r_dividend;
            r_error     <= 1'b1;
            r_overflow  <= 1'b0;
          end else begin
            r_quotient  <= w_q_val;
            r_remainder <= w_rem_val;
            r_error     <= 1'b0;
            r_overflow  <= w_q_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient_out   = r_quotient;
  assign remainder_out  = r_remainder;
  assign data_valid_out = r_valid;
  assign error_out      = r_error;
  assign overflow_out   = r_overflow;
  assign busy_out       = (r_state != StIdle);

endmodule

// File: tb/tb_serial_signed_divider.sv
// Scoreboard bench for serial_signed_divider: driver pushes model results, monitor pops on strobe.
module tb_serial_signed_divider;

  localparam int unsigned W       = 28;
  localparam int unsigned O       = 8;
  localparam int unsigned NumRand = 2000;
  localparam longint      QMax    = (longint'(1) << (O - 1)) - 1;
  localparam longint      QMin    = -(longint'(1) << (O - 1));
  localparam longint      DvdMin  = -(longint'(1) << (W - 1));
  localparam longint      DvdMax  = (longint'(1) << (W - 1)) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         valid_in;
  logic [O-1:0] quotient_out;
  logic [W-1:0] remainder_out;
  logic         data_valid_out;
  logic         error_out;
  logic         overflow_out;
  logic         busy_out;

  always #5 clk = ~clk;

  serial_signed_divider #(
    .WIDTH    (W),
    .OUT_SIZE (O)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .dividend_in    (dividend),
    .divisor_in     (divisor),
    .data_valid_in  (valid_in),
    .quotient_out   (quotient_out),
    .remainder_out  (remainder_out),
    .data_valid_out (data_valid_out),
    .error_out      (error_out),
    .overflow_out   (overflow_out),
    .busy_out       (busy_out)
  );

  typedef struct {
    longint q;
    longint r;
    bit     err;
    bit     ovf;
    longint at_edge;
  } exp_t;

  exp_t   sb[$];
  longint edge_cnt  = 0;
  longint free_edge = 0;
  int     n_checks  = 0;
  int     n_fail    = 0;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp_v, edge_cnt);
    end
  endtask

  // Reference: plain signed arithmetic, SV '/' and '%' truncate toward zero.
  function automatic exp_t model(input longint a, input longint b, input longint acc_edge);
    exp_t   e;
    longint qt;
    if (b == 0) begin
      e.q = 0; e.r = a; e.err = 1'b1; e.ovf = 1'b0; e.at_edge = acc_edge + 1;
    end else begin
      qt = a / b;
      e.r = a % b;
      e.err = 1'b0;
      e.at_edge = acc_edge + W + 1;
      e.ovf = 1'b1;
      if (qt > QMax) e.q = QMax;
      else if (qt < QMin) e.q = QMin;
      else begin
        e.q = qt;
        e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Called at posedge+2; the request is sampled on the following edge.
  task automatic issue(input longint a, input longint b);
    longint x;
    exp_t   e;
    dividend = W'(a);
    divisor  = W'(b);
    valid_in = 1'b1;
    @(posedge clk);
    #2;
    x = edge_cnt;
    valid_in = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    if (x >= free_edge) begin
      e = model(a, b, x);
      sb.push_back(e);
      free_edge = e.at_edge + 1;
    end
  endtask

  task automatic wait_free();
    while (edge_cnt + 1 < free_edge) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_quotient"}, longint'(quotient_out), 0);
    chk({tag, "_remainder"}, longint'(remainder_out), 0);
    chk({tag, "_valid"}, longint'(data_valid_out), 0);
    chk({tag, "_error"}, longint'(error_out), 0);
    chk({tag, "_overflow"}, longint'(overflow_out), 0);
    chk({tag, "_busy"}, longint'(busy_out), 0);
  endtask

  function automatic longint rnd_op(input bit is_divisor);
    logic signed [W-1:0] t;
    t = W'($urandom);
    case ($urandom_range(0, 9))
      0: return DvdMin;
      1: return DvdMax;
      2: return is_divisor ? 0 : longint'($urandom_range(0, 3));
      3: return ($urandom_range(0, 1) != 0) ? 1 : -1;
      4: return longint'($urandom_range(0, 40)) - 20;
      5: return longint'(t >>> $urandom_range(0, W - 2));
      default: return longint'(t);
    endcase
  endfunction

  // Monitor: pops on each strobe, otherwise checks the outputs hold.
  initial begin
    exp_t         e;
    logic [O-1:0] last_q   = '0;
    logic [W-1:0] last_r   = '0;
    logic         last_err = 1'b0;
    logic         last_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_q = '0; last_r = '0; last_err = 1'b0; last_ovf = 1'b0;
      end else if (data_valid_out) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got strobe at edge %0d, expected none", edge_cnt);
        end else begin
          e = sb.pop_front();
          chk("latency_edge", edge_cnt, e.at_edge);
          chk("quotient", longint'($signed(quotient_out)), e.q);
          chk("remainder", longint'($signed(remainder_out)), e.r);
          chk("error", longint'(error_out), longint'(e.err));
          chk("overflow", longint'(overflow_out), longint'(e.ovf));
          chk("busy_in_strobe", longint'(busy_out), 0);
        end
        last_q = quotient_out; last_r = remainder_out;
        last_err = error_out; last_ovf = overflow_out;
      end else begin
        chk("hold_quotient", longint'(quotient_out), longint'(last_q));
        chk("hold_remainder", longint'(remainder_out), longint'(last_r));
        chk("hold_error", longint'(error_out), longint'(last_err));
        chk("hold_overflow", longint'(overflow_out), longint'(last_ovf));
        if (sb.size() != 0 && edge_cnt > sb[0].at_edge) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_strobe: got none by edge %0d, expected at edge %0d",
                   edge_cnt, sb[0].at_edge);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    wait_free(); issue(100, 7);
    wait_free(); issue(-100, 7);
    wait_free(); issue(100, -7);
    wait_free(); issue(-100, -7);
    wait_free(); issue(1000, 3);
    wait_free(); issue(DvdMin, -1);
    wait_free(); issue(55, 0);
    wait_free(); issue(0, 5);
    wait_free(); issue(DvdMax, DvdMin);
    wait_free(); issue(-1000, 3);

    // A second pulse mid-division is dropped; the next request lands in the strobe cycle.
    wait_free(); issue(200, 9);
    repeat (5) begin @(posedge clk); #2; end
    issue(-3, 1);
    wait_free(); issue(77, -5);

    // Abort around iteration 10.
    wait_free(); issue(100, 7);
    repeat (10) begin @(posedge clk); #2; end
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    sb.delete();
    free_edge = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(9, 3);

    for (int i = 0; i < NumRand; i++) begin
      longint a;
      longint b;
      a = rnd_op(1'b0);
      b = rnd_op(1'b1);
      wait_free();
      issue(a, b);
    end

    wait_free();
    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
